// File: rtl/rom.sv
// Microcode decode ROM for the 4-bit processor control unit.
// Maps {opcode, carry, zero, phase} to a 13-bit control word, registered and tri-stated onto the control bus.
module rom (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [6:0]  addr,
    output logic [12:0] data
);

    localparam logic [12:0] WORD_NOP  = 13'b1000000001000;
    localparam logic [12:0] WORD_JMP  = 13'b0100000001000;
    localparam logic [12:0] WORD_NONE = 13'b1111111111111;

    logic [6:0]  addr_norm_s;
    logic [12:0] word_s;
    logic [12:0] q_r;

    // A floating (Z) address bit is folded into X so it cannot act as a casez wildcard on a decoded bit.
    assign addr_norm_s = addr ^ 7'b0000000;

    // Decode: fetch phase ignores the opcode; execute phase selects by opcode and, for branches, by a flag.
    always_comb begin
        word_s = WORD_NONE;
        if (addr_norm_s[0] == 1'b0) begin
            word_s = WORD_NOP;
        end else if (addr_norm_s[0] == 1'b1) begin
            casez (addr_norm_s[6:1])
                6'b0000_0?: word_s = WORD_NOP;
                6'b0000_1?: word_s = WORD_JMP;
                6'b0001_0?: word_s = WORD_JMP;
                6'b0001_1?: word_s = WORD_NOP;
                6'b0010_??: word_s = 13'b0001001000010;
                6'b0011_??: word_s = 13'b1001001100000;
                6'b0100_??: word_s = 13'b0011010000010;
                6'b0101_??: word_s = 13'b0011010000100;
                6'b0110_??: word_s = 13'b1011010100000;
                6'b0111_??: word_s = 13'b1000000111000;
                6'b1000_?0: word_s = WORD_NOP;
                6'b1000_?1: word_s = WORD_JMP;
                6'b1001_?0: word_s = WORD_JMP;
                6'b1001_?1: word_s = WORD_NOP;
                6'b1010_??: word_s = 13'b0011011000010;
                6'b1011_??: word_s = 13'b1011011100000;
                6'b1100_??: word_s = 13'b0100000001000;
                6'b1101_??: word_s = 13'b0000000001001;
                6'b1110_??: word_s = 13'b0011100000010;
                6'b1111_??: word_s = 13'b1011100100000;
                default:    word_s = WORD_NONE;
            endcase
        end else begin
            word_s = WORD_NONE;
        end
    end

    // Control-word register: reset wins over enable; a disabled block keeps its last word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r <= 13'h0000;
        end else if (en) begin
            q_r <= word_s;
        end else begin
            q_r <= q_r;
        end
    end

    // Bus drive follows en directly so release and re-drive happen without waiting for a clock.
    assign data = en ? q_r : 13'bzzzzzzzzzzzzz;

endmodule

// File: tb/tb_rom.sv
// Randomized self-checking bench for rom against a field-level decode model.
module tb_rom;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [6:0]  addr;
    logic [12:0] data;

    localparam logic [12:0] NOP  = 13'b1000000001000;
    localparam logic [12:0] JMP  = 13'b0100000001000;
    localparam logic [12:0] ALL1 = 13'b1111111111111;

    int          total_cnt;
    int          passed_cnt;
    logic        four_state;
    logic        probe;
    logic [12:0] q_ref;
    logic [12:0] exp;
    logic [12:0] exec_tbl [16];

    rom dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .addr  (addr),
        .data  (data)
    );

    always #5 clk = ~clk;

    // Reference decode from fields: fetch is a plain NOP, branches pick on one flag, the rest by opcode.
    function automatic logic [12:0] ref_word(input logic [6:0] a);
        logic [3:0] op;
        logic       cf;
        logic       zf;
        logic       ph;
        op = a[6:3];
        cf = a[2];
        zf = a[1];
        ph = a[0];
        if ($isunknown(ph)) return ALL1;
        if (ph == 1'b0) return NOP;
        if ($isunknown(op)) return ALL1;
        if (op == 4'd0 || op == 4'd1) begin
            if ($isunknown(cf)) return ALL1;
            return ((cf == 1'b1) ^ (op == 4'd1)) ? JMP : NOP;
        end
        if (op == 4'd8 || op == 4'd9) begin
            if ($isunknown(zf)) return ALL1;
            return ((zf == 1'b1) ^ (op == 4'd9)) ? JMP : NOP;
        end
        return exec_tbl[op];
    endfunction

    function automatic logic [12:0] exp_data();
        return en ? q_ref : 13'bzzzzzzzzzzzzz;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) q_ref = 13'h0000;
        else if (en) q_ref = ref_word(addr);
        else q_ref = q_ref;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        addr  = 7'($urandom_range(0, 127));
        tick();
        total_cnt++;
        if (data !== 13'h0000) $display("FAIL reset_value: got %b want %b", data, 13'h0000);
        else passed_cnt++;
        en = 1'b0;
        #1;
        exp = exp_data();
        if (four_state) begin
            total_cnt++;
            if (data !== exp) $display("FAIL reset_hiz: got %b want %b", data, exp);
            else passed_cnt++;
        end
    endtask

    task automatic test_fetch();
        rst_n = 1'b1;
        en    = 1'b1;
        addr  = 7'bxxxxxx0;
        tick();
        exp = exp_data();
        total_cnt++;
        if (data !== exp) $display("FAIL fetch_x: got %b want %b", data, exp);
        else passed_cnt++;
        for (int i = 0; i < 5; i++) begin
            addr = (i == 0) ? 7'b0101010 : {6'($urandom_range(0, 63)), 1'b0};
            tick();
            exp = exp_data();
            total_cnt++;
            if (data !== exp || data !== NOP)
                $display("FAIL fetch addr=%b: got %b want %b", addr, data, exp);
            else passed_cnt++;
        end
    endtask

    task automatic test_branches();
        logic [6:0] vec [8];
        vec = '{7'b0000011, 7'b0000101, 7'b0001011, 7'b0001101,
                7'b1000x11, 7'b1000x01, 7'b1001x11, 7'b1001x01};
        for (int i = 0; i < 8; i++) begin
            addr = vec[i];
            tick();
            exp = exp_data();
            total_cnt++;
            if (data !== exp) $display("FAIL branch addr=%b: got %b want %b", addr, data, exp);
            else passed_cnt++;
        end
    endtask

    task automatic test_sweep();
        for (int op = 2; op < 16; op++) begin
            addr = {4'(op), 2'bxx, 1'b1};
            tick();
            exp = exp_data();
            total_cnt++;
            if (data !== exp) $display("FAIL sweep op=%0d: got %b want %b", op, data, exp);
            else passed_cnt++;
        end
    endtask

    task automatic test_enable_hold();
        en   = 1'b1;
        addr = 7'b0011xx1;
        tick();
        total_cnt++;
        if (data !== 13'b1001001100000) $display("FAIL hold_load: got %b want %b", data, 13'b1001001100000);
        else passed_cnt++;
        en = 1'b0;
        #1;
        addr = 7'b1010xx1;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = exp_data();
            if (four_state) begin
                total_cnt++;
                if (data !== exp) $display("FAIL hold_hiz cycle %0d: got %b want %b", i, data, exp);
                else passed_cnt++;
            end
        end
        en = 1'b1;
        #1;
        total_cnt++;
        if (data !== 13'b1001001100000) $display("FAIL hold_redrive: got %b want %b", data, 13'b1001001100000);
        else passed_cnt++;
        tick();
        total_cnt++;
        if (data !== 13'b0011011000010) $display("FAIL hold_next: got %b want %b", data, 13'b0011011000010);
        else passed_cnt++;
    endtask

    task automatic test_default();
        en   = 1'b1;
        addr = 7'bx000001;
        tick();
        exp = exp_data();
        total_cnt++;
        if (data !== exp) $display("FAIL default: got %b want %b", data, exp);
        else passed_cnt++;
    endtask

    task automatic test_reset_mid();
        en   = 1'b1;
        addr = 7'b1111001;
        tick();
        en    = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        #1;
        total_cnt++;
        if (data !== 13'h0000) $display("FAIL reset_mid: got %b want %b", data, 13'h0000);
        else passed_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 19) != 0);
            en    = ($urandom_range(0, 3) != 0);
            addr  = 7'($urandom_range(0, 127));
            tick();
            exp = exp_data();
            if (en || four_state) begin
                total_cnt++;
                if (data !== exp)
                    $display("FAIL random #%0d addr=%b en=%b: got %b want %b", i, addr, en, data, exp);
                else passed_cnt++;
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        clk        = 1'b0;
        rst_n      = 1'b0;
        en         = 1'b0;
        addr       = 7'b0000000;
        total_cnt  = 0;
        passed_cnt = 0;
        q_ref      = 13'h0000;
        probe      = 1'bx;
        four_state = (probe === 1'bx);
        exec_tbl   = '{13'h0000, 13'h0000,
                       13'b0001001000010, 13'b1001001100000,
                       13'b0011010000010, 13'b0011010000100,
                       13'b1011010100000, 13'b1000000111000,
                       13'h0000, 13'h0000,
                       13'b0011011000010, 13'b1011011100000,
                       13'b0100000001000, 13'b0000000001001,
                       13'b0011100000010, 13'b1011100100000};
        test_reset();
        test_fetch();
        test_branches();
        test_sweep();
        test_enable_hold();
        test_default();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
